bcd_convert_arbiter: RTL

Shared, iterative binary-to-BCD conversion engine with a two-port round-robin arbiter. Two requesters, such as a score counter and a timer, each submit a 17-bit binary value. The block grants one at a time and runs a 17-cycle shift-and-add-3 (double-dabble) sequence. It returns a 5-digit packed BCD result tagged with the requester ID. It sits between the binary counters and the 7-segment display path, replacing per-requester combinational divide/modulo converters.

---
 rtl/bcd_convert_arbiter_if.sv | 28 ++
 rtl/bcd_convert_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bcd_convert_arbiter_if.sv
// Request/result bundle for the shared binary-to-BCD converter.
// The master modport is the requester side; the slave modport is the converter side.
interface bcd_convert_arbiter_if #(
    parameter int IN_W   = 17,
    parameter int DIGITS = 5
);
    logic                  req_a;
    logic [IN_W-1:0]       bin_a;
    logic                  req_b;
    logic [IN_W-1:0]       bin_b;
    logic                  gnt_a;
    logic                  gnt_b;
    logic                  busy;
    logic                  done;
    logic                  done_id;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  ovf;

    modport master (
        output req_a, bin_a, req_b, bin_b,
        input  gnt_a, gnt_b, busy, done, done_id, bcd_out, ovf
    );

    modport slave (
        input  req_a, bin_a, req_b, bin_b,
        output gnt_a, gnt_b, busy, done, done_id, bcd_out, ovf
    );
endinterface

// File: rtl/bcd_convert_arbiter.sv
// Two-port round-robin arbiter in front of an iterative double-dabble BCD converter.
// Optional macro BCD_SAT_EN: saturate bcd_out to all nines when the input overflows DIGITS digits.
module bcd_convert_arbiter #(
    parameter int IN_W   = 17,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bcd_convert_arbiter_if.slave  bus
);

    localparam int ACC_W = 4 * (DIGITS + 1);
    localparam int OUT_W = 4 * DIGITS;
    localparam logic [4:0] LAST_CNT = 5'(IN_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [IN_W-1:0]     sreg_q, sreg_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                cur_id_q, cur_id_d;
    logic                last_id_q, last_id_d;
    logic [OUT_W-1:0]    bcd_q, bcd_d;
    logic                ovf_q, ovf_d;
    logic                done_id_q, done_id_d;

    logic                gnt_a_w, gnt_b_w;
    logic [ACC_W-1:0]    acc_adj;

    // Add 3 to every digit that is 5 or more, so the following shift carries correctly.
    function automatic logic [ACC_W-1:0] add3(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] r;
        r = a;
        for (int d = 0; d < DIGITS + 1; d++) begin
            if (a[4*d +: 4] >= 4'd5) begin
                r[4*d +: 4] = a[4*d +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: assign a default before the case so no path leaves state_d unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (gnt_a_w || gnt_b_w) state_d = SHIFT;
            SHIFT:   if (cnt_q == LAST_CNT)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (grants only in IDLE; last_id breaks ties)
    // ------------------------------------------------------------------
    always_comb begin
        gnt_a_w = 1'b0;
        gnt_b_w = 1'b0;
        if (state_q == IDLE) begin
            if (bus.req_a && bus.req_b) begin
                gnt_a_w = last_id_q;
                gnt_b_w = !last_id_q;
            end else begin
                gnt_a_w = bus.req_a;
                gnt_b_w = bus.req_b;
            end
        end
    end

    assign bus.gnt_a   = gnt_a_w;
    assign bus.gnt_b   = gnt_b_w;
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.done_id = done_id_q;
    assign bus.bcd_out = bcd_q;
    assign bus.ovf     = ovf_q;

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    assign acc_adj = add3(acc_q);

    always_comb begin
        cnt_d     = cnt_q;
        sreg_d    = sreg_q;
        acc_d     = acc_q;
        cur_id_d  = cur_id_q;
        last_id_d = last_id_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        done_id_d = done_id_q;

        unique case (state_q)
            IDLE: begin
                if (gnt_a_w || gnt_b_w) begin
                    sreg_d    = gnt_b_w ? bus.bin_b : bus.bin_a;
                    acc_d     = '0;
                    cnt_d     = '0;
                    cur_id_d  = gnt_b_w;
                    last_id_d = gnt_b_w;
                end
            end
            SHIFT: begin
                {acc_d, sreg_d} = {acc_adj, sreg_q} << 1;
                cnt_d = cnt_q + 5'd1;
                // Result registers load on the edge into DONE so they are valid while done is high.
                if (cnt_q == LAST_CNT) begin
                    ovf_d     = (acc_d[ACC_W-1 -: 4] != 4'd0);
                    done_id_d = cur_id_q;
`ifdef BCD_SAT_EN
                    bcd_d = ovf_d ? {DIGITS{4'h9}} : acc_d[OUT_W-1:0];
`else
                    bcd_d = acc_d[OUT_W-1:0];
`endif
                end
            end
            default: ;
        endcase
    end

    // Reset returns to B as last winner so A takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            sreg_q    <= '0;
            acc_q     <= '0;
            cur_id_q  <= 1'b0;
            last_id_q <= 1'b1;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            done_id_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            sreg_q    <= sreg_d;
            acc_q     <= acc_d;
            cur_id_q  <= cur_id_d;
            last_id_q <= last_id_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            done_id_q <= done_id_d;
        end
    end

endmodule
